// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode map and controller states.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_SHL      = 3'b001,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110,
        ALU_MUL      = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        MUL   = 2'b10,
        DONE  = 2'b11
    } alu_state_e;

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit ripple-style adder with carry-in, carry-out and signed overflow.
module alu_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
    // Overflow when both addends share a sign that the sum does not.
    assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU with multi-cycle shift-left and optional multiply.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier for opcode 111.
module seq_alu #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);
    import seq_alu_pkg::*;

    localparam int CNT_W = SHAMT_W + 1;

    alu_state_e         state;
    alu_op_e            op_in;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_shl;
    logic [CNT_W-1:0]   cnt;
    logic [SHAMT_W-1:0] shamt;
    logic               is_sub;
    logic               multi;
    logic               finish;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cin;
    logic               add_cout;
    logic               add_ovf;

    logic [WIDTH-1:0]   one_res;
    logic               one_ovf;
    logic               one_cout;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_ovf;
    logic               fin_cout;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    assign op_in    = alu_op_e'(cntrl);
    assign shamt    = B[SHAMT_W-1:0];
    assign is_sub   = (op_in == ALU_SUBTRACT);
    assign work_shl = {work[WIDTH-2:0], 1'b0};
    assign in_ready = (state == IDLE) && reset_n;

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    // The adder serves live operands in IDLE and the accumulate step in MUL.
    always_comb begin
        add_a   = A;
        add_b   = is_sub ? ~B : B;
        add_cin = is_sub;
        if (state == MUL) begin
            add_a   = work;
            add_b   = mplier[0] ? mcand : '0;
            add_cin = 1'b0;
        end
    end

    assign multi = ((op_in == ALU_SHL) && (shamt != '0)) || (op_in == ALU_MUL);
`else
    always_comb begin
        add_a   = A;
        add_b   = is_sub ? ~B : B;
        add_cin = is_sub;
    end

    assign multi = (op_in == ALU_SHL) && (shamt != '0);
`endif

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Results of ops that finish on the accept edge; opcode 111 lands in default when the multiplier is absent.
    always_comb begin
        one_res  = '0;
        one_ovf  = 1'b0;
        one_cout = 1'b0;
        case (op_in)
            ALU_PASS_B: one_res = B;
            ALU_SHL:    one_res = A;
            ALU_ADD, ALU_SUBTRACT: begin
                one_res  = add_sum;
                one_ovf  = add_ovf;
                one_cout = add_cout;
            end
            ALU_AND:    one_res = A & B;
            ALU_OR:     one_res = A | B;
            ALU_XOR:    one_res = A ^ B;
            default:    one_res = '0;
        endcase
    end

    always_comb begin
        fin_res  = one_res;
        fin_ovf  = one_ovf;
        fin_cout = one_cout;
        if (state != IDLE) begin
            fin_res  = work_shl;
            fin_ovf  = 1'b0;
            fin_cout = 1'b0;
`ifdef SEQ_ALU_MUL_EN
            if (state == MUL) fin_res = add_sum;
`endif
        end
    end

    assign finish = ((state == IDLE) && in_valid && !multi) ||
                    (((state == SHIFT) || (state == MUL)) && (cnt == CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && (op_in == ALU_SHL) && (shamt != '0)) begin
                        work  <= A;
                        cnt   <= {1'b0, shamt};
                        state <= SHIFT;
                    end
`ifdef SEQ_ALU_MUL_EN
                    if (in_valid && (op_in == ALU_MUL)) begin
                        work   <= '0;
                        mcand  <= A;
                        mplier <= B;
                        cnt    <= CNT_W'(WIDTH);
                        state  <= MUL;
                    end
`endif
                end
                SHIFT: begin
                    work <= work_shl;
                    cnt  <= cnt - CNT_W'(1);
                end
`ifdef SEQ_ALU_MUL_EN
                MUL: begin
                    work   <= add_sum;
                    mcand  <= {mcand[WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Any completing op loads the registered outputs and parks in DONE.
            if (finish) begin
                result    <= fin_res;
                negative  <= fin_res[WIDTH-1];
                zero      <= is_zero(fin_res);
                overflow  <= fin_ovf;
                carry_out <= fin_cout;
                out_valid <= 1'b1;
                state     <= DONE;
            end
        end
    end

endmodule
